// File: rtl/strip_geom_pkg.sv
// Shared strip geometry for the compute array: limits, FSM state type and
// the strip start-row function used by both placement and readback paths.
package strip_geom_pkg;

  localparam int STRIP_ID_MIN     = 1;
  localparam int STRIP_ID_MAX     = 13;
  localparam int Y_LIMIT          = 128;
  localparam int STRIP_MAX_OFFSET = 15;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // First array row of strip k (valid for k = 1..13). Odd strips sit on an
  // 8-row grid, even strips are pulled down by (9 - k/2) rows, and the two
  // last strips are 16 rows tall.
  function automatic logic [7:0] strip_start(input logic [3:0] k);
    logic [7:0] k8;
    logic [7:0] res;
    k8 = {4'b0000, k};
    if (k >= 4'd12) begin
      res = {k, 4'b0000} - 8'd96;
    end else if (k[0]) begin
      res = {k8[4:0] - 5'd1, 3'b000};
    end else begin
      res = {k8[4:0], 3'b000} - (8'd9 - {5'b00000, k[3:1]});
    end
    return res;
  endfunction

endpackage

// File: rtl/y_to_strip_id_if.sv
// Query and result handshake channels of the y-to-strip locator.
interface y_to_strip_id_if;

  logic       y_valid_i;
  logic       y_ready_o;
  logic [7:0] y_i;
  logic       res_valid_o;
  logic       res_ready_i;
  logic [3:0] strip_id_o;
  logic [3:0] offset_o;
  logic       error_o;

  // Requester side: issues y queries and consumes results.
  modport master (
    output y_valid_i, y_i, res_ready_i,
    input  y_ready_o, res_valid_o, strip_id_o, offset_o, error_o
  );

  // Locator side: accepts queries and produces results.
  modport slave (
    input  y_valid_i, y_i, res_ready_i,
    output y_ready_o, res_valid_o, strip_id_o, offset_o, error_o
  );

endinterface

// File: rtl/strip_start_y.sv
// Combinational strip id to start-row lookup.
module strip_start_y
  import strip_geom_pkg::*;
(
  input  logic [3:0] id,
  output logic [7:0] start_y
);

  assign start_y = strip_start(id);

endmodule

// File: rtl/y_to_strip_id.sv
// Inverse strip locator: scans strip start rows one candidate per cycle and
// reports the strip containing a y position plus the row offset inside it.
module y_to_strip_id
  import strip_geom_pkg::*;
(
  input logic              clk_i,
  input logic              rst_i,
  y_to_strip_id_if.slave   bus
);

  localparam logic [3:0] LAST_ID    = 4'(STRIP_ID_MAX);
  localparam logic [7:0] LAST_START = strip_start(4'(STRIP_ID_MAX));
  localparam logic [7:0] Y_LIM8     = 8'(Y_LIMIT);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] y_q;
  logic       res_valid;
  logic [3:0] strip_id;
  logic [3:0] offset;
  logic       error;

  logic [3:0] cnt_prev;
  logic [7:0] start_cnt;
  logic [7:0] start_prev;
  logic [3:0] offset_prev;
  logic [3:0] offset_last;
  logic       unused_start_bits;

  assign cnt_prev = cnt - 4'd1;

  strip_start_y u_start_cnt (
    .id      (cnt),
    .start_y (start_cnt)
  );

  strip_start_y u_start_prev (
    .id      (cnt_prev),
    .start_y (start_prev)
  );

  // Gaps between starts never exceed 16 rows, so only the low nibble of the
  // difference matters and it can be taken from the low nibbles alone.
  assign offset_prev       = y_q[3:0] - start_prev[3:0];
  assign offset_last       = y_q[3:0] - LAST_START[3:0];
  assign unused_start_bits = ^start_prev[7:4];

  // Query/result FSM with counter, latched y and registered result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 4'd2;
      y_q       <= 8'd0;
      res_valid <= 1'b0;
      strip_id  <= 4'd0;
      offset    <= 4'd0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.y_valid_i) begin
            y_q   <= bus.y_i;
            cnt   <= 4'd2;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (y_q >= Y_LIM8) begin
            strip_id  <= 4'd0;
            offset    <= 4'd0;
            error     <= 1'b1;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (start_cnt > y_q) begin
            strip_id  <= cnt_prev;
            offset    <= offset_prev;
            error     <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == LAST_ID) begin
            strip_id  <= LAST_ID;
            offset    <= offset_last;
            error     <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (bus.res_ready_i) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.y_ready_o   = (state == IDLE);
  assign bus.res_valid_o = res_valid;
  assign bus.strip_id_o  = strip_id;
  assign bus.offset_o    = offset;
  assign bus.error_o     = error;

endmodule

// File: tb/tb_y_to_strip_id.sv
// Directed self-checking bench for the y-to-strip locator.
module tb_y_to_strip_id;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   failures;

  y_to_strip_id_if bus ();

  y_to_strip_id dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue one query, measure latency, check the result, then complete the
  // result handshake after hold_cycles of backpressure.
  task automatic apply_stimulus(input logic [7:0] y, input int exp_id,
                                input int exp_off, input int exp_err,
                                input int exp_lat, input int hold_cycles);
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    while (!bus.y_ready_o && wait_cnt < 40) begin
      tick();
      wait_cnt++;
    end
    check_output($sformatf("ready_before_y%0d", y), 32'(bus.y_ready_o), 32'd1);
    bus.y_valid_i = 1'b1;
    bus.y_i       = y;
    tick();
    bus.y_valid_i = 1'b0;
    lat = 0;
    while (!bus.res_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    check_output($sformatf("latency_y%0d", y), 32'(lat), 32'(exp_lat));
    check_output($sformatf("id_y%0d", y), 32'(bus.strip_id_o), 32'(exp_id));
    check_output($sformatf("offset_y%0d", y), 32'(bus.offset_o), 32'(exp_off));
    check_output($sformatf("error_y%0d", y), 32'(bus.error_o), 32'(exp_err));
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      check_output($sformatf("hold%0d_valid_y%0d", i, y), 32'(bus.res_valid_o), 32'd1);
      check_output($sformatf("hold%0d_id_y%0d", i, y), 32'(bus.strip_id_o), 32'(exp_id));
      check_output($sformatf("hold%0d_offset_y%0d", i, y), 32'(bus.offset_o), 32'(exp_off));
      check_output($sformatf("hold%0d_ready_y%0d", i, y), 32'(bus.y_ready_o), 32'd0);
    end
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    check_output($sformatf("post_valid_y%0d", y), 32'(bus.res_valid_o), 32'd0);
    check_output($sformatf("post_ready_y%0d", y), 32'(bus.y_ready_o), 32'd1);
  endtask

  // Directed test sequence.
  initial begin
    int seen_valid;
    checks          = 0;
    failures        = 0;
    rst_i           = 1'b1;
    bus.y_valid_i   = 1'b0;
    bus.y_i         = 8'd0;
    bus.res_ready_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    check_output("reset_ready", 32'(bus.y_ready_o), 32'd1);
    check_output("reset_valid", 32'(bus.res_valid_o), 32'd0);
    check_output("reset_id", 32'(bus.strip_id_o), 32'd0);
    check_output("reset_offset", 32'(bus.offset_o), 32'd0);
    check_output("reset_error", 32'(bus.error_o), 32'd0);

    apply_stimulus(8'd0,   1,  0, 0, 1,  0);
    apply_stimulus(8'd24,  3,  8, 0, 3,  0);
    apply_stimulus(8'd25,  4,  0, 0, 4,  0);
    apply_stimulus(8'd111, 12, 15, 0, 12, 0);
    apply_stimulus(8'd127, 13, 15, 0, 12, 0);
    apply_stimulus(8'd200, 0,  0, 1, 1,  0);
    apply_stimulus(8'd64,  9,  0, 0, 9,  0);
    apply_stimulus(8'd79,  10, 3, 0, 10, 5);

    // Reset in the middle of a scan must discard the pending result.
    bus.y_valid_i = 1'b1;
    bus.y_i       = 8'd100;
    tick();
    bus.y_valid_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_output("abort_ready", 32'(bus.y_ready_o), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid_o) seen_valid = 1;
      tick();
    end
    check_output("abort_no_valid", 32'(seen_valid), 32'd0);

    apply_stimulus(8'd8, 2, 0, 0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
